nx_stream_arbiter: RTL and testbench
====================================

Name: nx_stream_arbiter

Overview:
- Merges four inbound message streams (north, east, south, west) onto one outbound stream using round-robin arbitration.
- It is the counterpart to the distributer: the distributer fans one stream out by direction, and this block fans four directional streams in.
- The outbound stream carries a 2-bit source-direction tag.
- The output is registered: a one-entry stage gives a 1-cycle latency at full throughput.

Parameters:
STREAM_WIDTH, 32, width of message data on all streams
COUNT_WIDTH, 16, width of per-direction grant counters (used only with NX_ARB_STATS_EN)

Ports:
clk_i  input  1  clock
rst_i  input  1  reset; synchronous, active-high
north_data_i  input  STREAM_WIDTH  north inbound data
north_valid_i  input  1  north inbound valid
north_ready_o  output  1  north inbound ready
east_data_i / east_valid_i / east_ready_o  as north, for east
south_data_i / south_valid_i / south_ready_o  as north, for south
west_data_i / west_valid_i / west_ready_o  as north, for west
arb_data_o  output  STREAM_WIDTH  outbound data (registered)
arb_dir_o  output  2  source direction of arb_data_o: NORTH=0, EAST=1, SOUTH=2, WEST=3 (registered)
arb_valid_o  output  1  outbound valid (registered)
arb_ready_i  input  1  outbound ready from consumer

Behaviour:
- Handshake: a transfer occurs on a cycle where valid && ready. Producers hold valid and data stable until accepted. arb_valid_o, once high, stays high with stable data and dir until arb_ready_i.
- Load enable: load = !arb_valid_o || arb_ready_i. This is combinational from arb_ready_i to the *_ready_o outputs.
- Grant: when load is high, the first direction with valid high wins. The search starts at rr_ptr and proceeds rr_ptr+1, +2, +3, all mod 4.
- Only the granted direction's ready_o is high. At most one *_ready_o is high in any cycle. All *_ready_o are low when load is low or no valid is high.
- On a grant, the next edge sets:
  - arb_data_o to the granted data
  - arb_dir_o to the granted direction
  - arb_valid_o to 1
  - rr_ptr to (granted + 1) mod 4 (wraps WEST -> NORTH)
- Load with no grant: the next edge sets arb_valid_o to 0. Data and dir hold their last values. rr_ptr is unchanged.
- No load (output stalled): all registers hold and no input is accepted.
- Throughput: one message per cycle while arb_ready_i stays high. Latency: an input accepted in cycle N is presented on the output in cycle N+1.
- Fairness: with all four requesting continuously, grant order is a strict rotation. No requester waits more than 3 other grants.
- Reset, taking effect on the next clock edge while rst_i is high:
  - arb_valid_o=0, arb_data_o=0, arb_dir_o=0, rr_ptr=NORTH
  - all *_ready_o=0 while rst_i is high
  - a message held in the output stage is discarded; no input is accepted during reset
- Simultaneous events: when a consume (arb_valid_o && arb_ready_i) and a new grant occur in the same cycle, the output stage is replaced, giving back-to-back transfers with no bubble.

Optional Feature:
- Macro: NX_ARB_STATS_EN.
- When defined:
  - Adds output ports north_count_o, east_count_o, south_count_o, west_count_o, each COUNT_WIDTH wide.
  - Each counter increments by 1 on every accepted inbound transfer for its direction.
  - Counters saturate at all-ones and do not wrap.
  - Reset to 0 on rst_i.
- When undefined: these ports and counters do not exist, and arbitration behaviour is identical.

Test Plan:
- Reset: hold rst_i 2 cycles with all valids high -> all *_ready_o=0 and arb_valid_o=0 throughout. After release, the first grant is NORTH.
- Rotation: all four valid continuously, arb_ready_i=1, data N=0x10, E=0x20, S=0x30, W=0x40 -> output dir sequence 0,1,2,3,0,1… with matching data, one per cycle.
- Skip and wrap: only east and west valid, rr_ptr=SOUTH -> west granted first, then east (the pointer wraps past NORTH), alternating thereafter.
- Backpressure: arb_valid_o=1 holding 0xAB from S, arb_ready_i=0 for 5 cycles with north valid -> output stable, north_ready_o=0. When arb_ready_i=1, 0xAB is consumed and north is accepted in the same cycle.
- Reset mid-operation: assert rst_i while arb_valid_o=1 with data 0x55 -> next cycle arb_valid_o=0 and rr_ptr=NORTH; 0x55 is never emitted.
- NX_ARB_STATS_EN with COUNT_WIDTH=4: 20 consecutive north-only transfers -> north_count_o reaches 15 and stays at 15; other counters remain 0.

Source files
------------

// File: rtl/nx_stream_arbiter.sv
// rtl/nx_stream_arbiter.sv - four-way round-robin stream merger with a registered output stage
// Optional per-direction grant counters are enabled by defining NX_ARB_STATS_EN.
module nx_stream_arbiter #(
    parameter int STREAM_WIDTH = 32,
    parameter int COUNT_WIDTH  = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [STREAM_WIDTH-1:0] north_data_i,
    input  logic                    north_valid_i,
    output logic                    north_ready_o,
    input  logic [STREAM_WIDTH-1:0] east_data_i,
    input  logic                    east_valid_i,
    output logic                    east_ready_o,
    input  logic [STREAM_WIDTH-1:0] south_data_i,
    input  logic                    south_valid_i,
    output logic                    south_ready_o,
    input  logic [STREAM_WIDTH-1:0] west_data_i,
    input  logic                    west_valid_i,
    output logic                    west_ready_o,
`ifdef NX_ARB_STATS_EN
    output logic [COUNT_WIDTH-1:0]  north_count_o,
    output logic [COUNT_WIDTH-1:0]  east_count_o,
    output logic [COUNT_WIDTH-1:0]  south_count_o,
    output logic [COUNT_WIDTH-1:0]  west_count_o,
`endif
    output logic [STREAM_WIDTH-1:0] arb_data_o,
    output logic [1:0]              arb_dir_o,
    output logic                    arb_valid_o,
    input  logic                    arb_ready_i
);

    logic [STREAM_WIDTH-1:0] r_data;
    logic [1:0]              r_dir;
    logic                    r_valid;
    logic [1:0]              r_rr_ptr;

    logic [3:0]              w_valid;
    logic                    w_load;
    logic                    w_grant;
    logic [1:0]              w_gdir;
    logic [1:0]              w_idx;
    logic [STREAM_WIDTH-1:0] w_gdata;
    logic [3:0]              w_ready;

    assign w_valid = {west_valid_i, south_valid_i, east_valid_i, north_valid_i};
    assign w_load  = !r_valid || arb_ready_i;

    // Scan from the farthest candidate back to rr_ptr so the nearest requester wins.
    always_comb begin
        w_grant = 1'b0;
        w_gdir  = r_rr_ptr;
        w_idx   = r_rr_ptr;
        for (int i = 3; i >= 0; i--) begin
            w_idx = r_rr_ptr + 2'(i);
            if (w_valid[w_idx]) begin
                w_grant = 1'b1;
                w_gdir  = w_idx;
            end
        end
    end

    always_comb begin
        case (w_gdir)
            2'd0:    w_gdata = north_data_i;
            2'd1:    w_gdata = east_data_i;
            2'd2:    w_gdata = south_data_i;
            default: w_gdata = west_data_i;
        endcase
    end

    assign w_ready = (w_load && w_grant && !rst_i) ? (4'b0001 << w_gdir) : 4'b0000;

    assign north_ready_o = w_ready[0];
    assign east_ready_o  = w_ready[1];
    assign south_ready_o = w_ready[2];
    assign west_ready_o  = w_ready[3];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_valid  <= 1'b0;
            r_data   <= '0;
            r_dir    <= 2'd0;
            r_rr_ptr <= 2'd0;
        end else if (w_load) begin
            if (w_grant) begin
                r_valid  <= 1'b1;
                r_data   <= w_gdata;
                r_dir    <= w_gdir;
                r_rr_ptr <= w_gdir + 2'd1;
            end else begin
                r_valid  <= 1'b0;
            end
        end
    end

    assign arb_data_o  = r_data;
    assign arb_dir_o   = r_dir;
    assign arb_valid_o = r_valid;

`ifdef NX_ARB_STATS_EN
    logic [COUNT_WIDTH-1:0] r_count [4];

    // Counters saturate rather than wrap so a long run never reads as a short one.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < 4; i++) begin
            if (rst_i) begin
                r_count[i] <= '0;
            end else if (w_ready[i] && (r_count[i] != '1)) begin
                r_count[i] <= r_count[i] + COUNT_WIDTH'(1);
            end
        end
    end

    assign north_count_o = r_count[0];
    assign east_count_o  = r_count[1];
    assign south_count_o = r_count[2];
    assign west_count_o  = r_count[3];
`endif

endmodule

// File: tb/tb_nx_stream_arbiter.sv
// tb/tb_nx_stream_arbiter.sv - directed and randomized checks of nx_stream_arbiter against a cycle model
module tb_nx_stream_arbiter;

`ifdef NX_ARB_STATS_EN
    localparam int CW = 4;
`else
    localparam int CW = 16;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_data [4];
    logic [3:0]  in_valid;
    logic        arb_ready;

    logic        n_rdy, e_rdy, s_rdy, w_rdy;
    logic [31:0] arb_data;
    logic [1:0]  arb_dir;
    logic        arb_valid;
    logic [3:0]  rdy;

`ifdef NX_ARB_STATS_EN
    logic [CW-1:0] cnt_n, cnt_e, cnt_s, cnt_w;
`endif

    int checks = 0;
    int errors = 0;

    bit          m_valid;
    logic [31:0] m_data;
    int          m_dir;
    int          m_rr;
    bit [3:0]    m_acc;
    int          m_cnt [4];

    always #5 clk = ~clk;

    assign rdy = {w_rdy, s_rdy, e_rdy, n_rdy};

    nx_stream_arbiter #(.STREAM_WIDTH(32), .COUNT_WIDTH(CW)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .north_data_i  (in_data[0]),
        .north_valid_i (in_valid[0]),
        .north_ready_o (n_rdy),
        .east_data_i   (in_data[1]),
        .east_valid_i  (in_valid[1]),
        .east_ready_o  (e_rdy),
        .south_data_i  (in_data[2]),
        .south_valid_i (in_valid[2]),
        .south_ready_o (s_rdy),
        .west_data_i   (in_data[3]),
        .west_valid_i  (in_valid[3]),
        .west_ready_o  (w_rdy),
`ifdef NX_ARB_STATS_EN
        .north_count_o (cnt_n),
        .east_count_o  (cnt_e),
        .south_count_o (cnt_s),
        .west_count_o  (cnt_w),
`endif
        .arb_data_o    (arb_data),
        .arb_dir_o     (arb_dir),
        .arb_valid_o   (arb_valid),
        .arb_ready_i   (arb_ready)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: check outputs at the falling edge, then advance the model past the rising edge.
    task automatic cycle();
        int  g;
        bit  load;
        int  sat;
        @(negedge clk);
        load = !m_valid || arb_ready;
        g = -1;
        for (int k = 0; k < 4; k++)
            if (g < 0 && in_valid[(m_rr + k) % 4]) g = (m_rr + k) % 4;
        m_acc = '0;
        if (!rst && load && g >= 0) m_acc[g] = 1'b1;
        chk("ready", 64'(rdy), 64'(m_acc));
        chk("valid", 64'(arb_valid), 64'(m_valid));
        if (m_valid) begin
            chk("data", 64'(arb_data), 64'(m_data));
            chk("dir", 64'(arb_dir), 64'(m_dir));
        end
`ifdef NX_ARB_STATS_EN
        chk("cnt_n", 64'(cnt_n), 64'(m_cnt[0]));
        chk("cnt_e", 64'(cnt_e), 64'(m_cnt[1]));
        chk("cnt_s", 64'(cnt_s), 64'(m_cnt[2]));
        chk("cnt_w", 64'(cnt_w), 64'(m_cnt[3]));
`endif
        @(posedge clk);
        #1;
        sat = (1 << CW) - 1;
        if (rst) begin
            m_valid = 0; m_data = '0; m_dir = 0; m_rr = 0;
            for (int d = 0; d < 4; d++) m_cnt[d] = 0;
        end else if (load) begin
            if (g >= 0) begin
                m_valid = 1; m_data = in_data[g]; m_dir = g; m_rr = (g + 1) % 4;
                if (m_cnt[g] < sat) m_cnt[g]++;
            end else begin
                m_valid = 0;
            end
        end
    endtask

    initial begin
        rst = 1'b1; arb_ready = 1'b0; in_valid = 4'b1111;
        for (int d = 0; d < 4; d++) begin in_data[d] = 32'((d + 1) * 16); m_cnt[d] = 0; end
        m_valid = 0; m_data = '0; m_dir = 0; m_rr = 0;
        @(posedge clk); #1;

        // reset held two cycles with every producer requesting
        cycle(); cycle();
        chk("rst_valid", 64'(arb_valid), 64'd0);
        chk("rst_data", 64'(arb_data), 64'd0);

        // rotation straight out of reset, starting at north
        rst = 1'b0; arb_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cycle();
            chk("rot_dir", 64'(arb_dir), 64'(i % 4));
            chk("rot_data", 64'(arb_data), 64'(((i % 4) + 1) * 16));
        end

        // skip and wrap: pointer parked at south, only east and west request
        rst = 1'b1; cycle(); rst = 1'b0;
        in_valid = 4'b0010; cycle();
        in_valid = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("wrap_dir", 64'(arb_dir), (i % 2 == 0) ? 64'd3 : 64'd1);
        end

        // backpressure holding 0xAB from south
        in_valid = 4'b0100; in_data[2] = 32'hAB; cycle();
        in_valid = 4'b0001; in_data[0] = 32'h77; arb_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("bp_data", 64'(arb_data), 64'hAB);
            chk("bp_nrdy", 64'(n_rdy), 64'd0);
        end
        arb_ready = 1'b1; #1;
        chk("bp_release_nrdy", 64'(n_rdy), 64'd1);
        cycle();
        chk("bp_next_data", 64'(arb_data), 64'h77);
        chk("bp_next_dir", 64'(arb_dir), 64'd0);

        // reset while 0x55 sits in the output stage
        in_data[0] = 32'h55; cycle();
        arb_ready = 1'b0; in_valid = 4'b0000; rst = 1'b1; cycle();
        chk("mid_rst_valid", 64'(arb_valid), 64'd0);
        rst = 1'b0; arb_ready = 1'b1; in_valid = 4'b1111;
        for (int d = 0; d < 4; d++) in_data[d] = 32'((d + 1) * 16);
        cycle();
        chk("mid_rst_dir", 64'(arb_dir), 64'd0);
        chk("mid_rst_data", 64'(arb_data), 64'h10);

`ifdef NX_ARB_STATS_EN
        // saturation of the north counter
        rst = 1'b1; cycle(); rst = 1'b0;
        in_valid = 4'b0001; arb_ready = 1'b1;
        for (int i = 0; i < 20; i++) cycle();
        chk("sat_north", 64'(cnt_n), 64'd15);
        chk("sat_east", 64'(cnt_e), 64'd0);
`endif

        // randomized traffic with producers holding valid/data until accepted
        for (int i = 0; i < 3000; i++) begin
            cycle();
            for (int d = 0; d < 4; d++) begin
                if (m_acc[d] || !in_valid[d]) begin
                    in_valid[d] = ($urandom_range(0, 3) != 0);
                    in_data[d]  = $urandom;
                end
            end
            arb_ready = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 299) == 0);
        end
        rst = 1'b0;
        cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
